// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge.
// Pipelines address, write data and direction over two register stages,
// qualifies transfers, decodes the three APB peripheral selects, passes
// APB read data straight back to AHB and always answers OKAY.
module ahb_slave_interface (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic [31:0] Hrdata,
  output logic        Hwritereg,
  output logic [2:0]  tempselx,
  output logic [1:0]  Hresp
);

  localparam logic [31:0] ADDR_LO = 32'h8000_0000;
  localparam logic [31:0] ADDR_HI = 32'h8C00_0000;

  logic [31:0] r_haddr1;
  logic [31:0] r_haddr2;
  logic [31:0] r_hwdata1;
  logic [31:0] r_hwdata2;
  logic        r_hwritereg;

  logic        w_in_range;
  logic        w_valid;
  logic [2:0]  w_tempselx;

  // Two-stage address/data pipeline and one-stage direction register;
  // loads every edge regardless of transfer type, reset wins over loads.
  always_ff @(posedge Hclk) begin
    if (Hresetn) begin
      r_haddr1    <= 32'h0000_0000;
      r_haddr2    <= 32'h0000_0000;
      r_hwdata1   <= 32'h0000_0000;
      r_hwdata2   <= 32'h0000_0000;
      r_hwritereg <= 1'b0;
    end else begin
      r_haddr1    <= Haddr;
      r_haddr2    <= r_haddr1;
      r_hwdata1   <= Hwdata;
      r_hwdata2   <= r_hwdata1;
      r_hwritereg <= Hwrite;
    end
  end

  // Peripheral select decode from the live address: each slot spans
  // 64 MB, so the top six address bits identify the slot.
  always_comb begin
    w_tempselx = 3'b000;
    case (Haddr[31:26])
      6'b100000: w_tempselx = 3'b001;
      6'b100001: w_tempselx = 3'b010;
      6'b100010: w_tempselx = 3'b100;
      default:   w_tempselx = 3'b000;
    endcase
  end

  // Transfer qualification: ready bus, NONSEQ/SEQ, address inside the map.
  always_comb begin
    w_in_range = 1'b0;
    w_valid    = 1'b0;
    if ((Haddr >= ADDR_LO) && (Haddr < ADDR_HI)) begin
      w_in_range = 1'b1;
    end else begin
      w_in_range = 1'b0;
    end
    if (Hreadyin && Htrans[1] && w_in_range) begin
      w_valid = 1'b1;
    end else begin
      w_valid = 1'b0;
    end
  end

  assign valid     = w_valid;
  assign tempselx  = w_tempselx;
  assign Haddr1    = r_haddr1;
  assign Haddr2    = r_haddr2;
  assign Hwdata1   = r_hwdata1;
  assign Hwdata2   = r_hwdata2;
  assign Hwritereg = r_hwritereg;
  assign Hrdata    = Prdata;
  assign Hresp     = 2'b00;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed self-checking bench for ahb_slave_interface.
module tb_ahb_slave_interface;

  logic        Hclk;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        valid;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata1;
  logic [31:0] Hwdata2;
  logic [31:0] Hrdata;
  logic        Hwritereg;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  int errors = 0;
  int checks = 0;

  logic [31:0] burst [5];

  ahb_slave_interface dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Prdata    (Prdata),
    .valid     (valid),
    .Haddr1    (Haddr1),
    .Haddr2    (Haddr2),
    .Hwdata1   (Hwdata1),
    .Hwdata2   (Hwdata2),
    .Hrdata    (Hrdata),
    .Hwritereg (Hwritereg),
    .tempselx  (tempselx),
    .Hresp     (Hresp)
  );

  // Free-running clock, 10 time-unit period.
  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle one time unit past it.
  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    burst[0] = 32'h8000_0000;
    burst[1] = 32'h8000_0004;
    burst[2] = 32'h8000_0008;
    burst[3] = 32'h8000_000C;
    burst[4] = 32'h8000_0000;

    // Reset with nonzero inputs
    Hresetn  = 1'b1;
    Hwrite   = 1'b1;
    Hreadyin = 1'b1;
    Htrans   = 2'b10;
    Haddr    = 32'h1111_1111;
    Hwdata   = 32'h2222_2222;
    Prdata   = 32'h0000_0000;
    step();
    check("rst_haddr1",   Haddr1,    32'h0);
    check("rst_haddr2",   Haddr2,    32'h0);
    check("rst_hwdata1",  Hwdata1,   32'h0);
    check("rst_hwdata2",  Hwdata2,   32'h0);
    check("rst_hwritereg", {31'h0, Hwritereg}, 32'h0);

    // NONSEQ write to slot 0
    Hresetn = 1'b0;
    Haddr   = 32'h8000_0010;
    Hwdata  = 32'h1234_5678;
    Hwrite  = 1'b1;
    Htrans  = 2'b10;
    #1;
    check("wr_valid",    {31'h0, valid}, 32'h1);
    check("wr_tempselx", {29'h0, tempselx}, 32'h1);
    step();
    check("wr_haddr1",    Haddr1,  32'h8000_0010);
    check("wr_haddr2_0",  Haddr2,  32'h0);
    check("wr_hwdata1",   Hwdata1, 32'h1234_5678);
    check("wr_hwdata2_0", Hwdata2, 32'h0);
    check("wr_hwritereg", {31'h0, Hwritereg}, 32'h1);

    // Read passthrough, SEQ to slot 1
    Hwrite = 1'b0;
    Prdata = 32'hABCD_EF01;
    Haddr  = 32'h8400_0020;
    Htrans = 2'b11;
    Hwdata = 32'h0000_0000;
    #1;
    check("rd_hrdata",   Hrdata, 32'hABCD_EF01);
    check("rd_hresp",    {30'h0, Hresp}, 32'h0);
    check("sel1_tempselx", {29'h0, tempselx}, 32'h2);
    check("sel1_valid",  {31'h0, valid}, 32'h1);
    step();
    check("wr_haddr2",    Haddr2,  32'h8000_0010);
    check("wr_hwdata2",   Hwdata2, 32'h1234_5678);
    check("rd_haddr1",    Haddr1,  32'h8400_0020);
    check("rd_hwdata1",   Hwdata1, 32'h0);
    check("rd_hwritereg", {31'h0, Hwritereg}, 32'h0);

    // Hrdata follows Prdata on a write as well
    Hwrite = 1'b1;
    Prdata = 32'h5A5A_0F0F;
    #1;
    check("wr_hrdata", Hrdata, 32'h5A5A_0F0F);

    // Decode and range boundaries
    Haddr = 32'h8800_0000; #1;
    check("sel2_tempselx", {29'h0, tempselx}, 32'h4);
    check("sel2_valid",    {31'h0, valid}, 32'h1);
    Haddr = 32'h8BFF_FFFF; #1;
    check("top_tempselx", {29'h0, tempselx}, 32'h4);
    check("top_valid",    {31'h0, valid}, 32'h1);
    Haddr = 32'h8C00_0000; #1;
    check("above_tempselx", {29'h0, tempselx}, 32'h0);
    check("above_valid",    {31'h0, valid}, 32'h0);
    Haddr = 32'h7FFF_FFFF; #1;
    check("below_tempselx", {29'h0, tempselx}, 32'h0);
    check("below_valid",    {31'h0, valid}, 32'h0);
    Haddr = 32'h9000_0000; Htrans = 2'b10; #1;
    check("out_tempselx", {29'h0, tempselx}, 32'h0);
    check("out_valid",    {31'h0, valid}, 32'h0);

    // Qualification: IDLE, BUSY, not ready
    Haddr = 32'h8000_0000; Htrans = 2'b00; #1;
    check("idle_valid",    {31'h0, valid}, 32'h0);
    check("idle_tempselx", {29'h0, tempselx}, 32'h1);
    Htrans = 2'b01; #1;
    check("busy_valid", {31'h0, valid}, 32'h0);
    Htrans = 2'b10; Hreadyin = 1'b0; #1;
    check("nrdy_valid",    {31'h0, valid}, 32'h0);
    check("nrdy_tempselx", {29'h0, tempselx}, 32'h1);
    Hreadyin = 1'b1; #1;
    check("lo_edge_valid", {31'h0, valid}, 32'h1);

    // Wrapping burst through the pipeline
    for (int i = 0; i < 5; i++) begin
      Haddr  = burst[i];
      Hwdata = 32'hD000_0000 + i;
      Htrans = (i == 0) ? 2'b10 : 2'b11;
      #1;
      check($sformatf("burst_valid_%0d", i), {31'h0, valid}, 32'h1);
      step();
      check($sformatf("burst_haddr1_%0d", i), Haddr1, burst[i]);
      if (i > 0) begin
        check($sformatf("burst_haddr2_%0d", i), Haddr2, burst[i-1]);
        check($sformatf("burst_hwdata2_%0d", i), Hwdata2, 32'hD000_0000 + i - 1);
      end
    end

    // Reset mid-burst overrides loads
    Hresetn = 1'b1;
    Haddr   = 32'h8000_0004;
    Hwdata  = 32'hFFFF_FFFF;
    step();
    check("mid_rst_haddr1",  Haddr1,  32'h0);
    check("mid_rst_haddr2",  Haddr2,  32'h0);
    check("mid_rst_hwdata1", Hwdata1, 32'h0);
    check("mid_rst_hwritereg", {31'h0, Hwritereg}, 32'h0);
    check("mid_rst_valid",  {31'h0, valid}, 32'h1);
    Hresetn = 1'b0;
    step();
    check("post_rst_haddr1", Haddr1, 32'h8000_0004);
    check("post_rst_haddr2", Haddr2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
AHB-side front end of the AHB-to-APB bridge. It pipelines the AHB address, write data and write direction over two register stages. It also qualifies transfers (valid) and decodes one of three APB peripheral selects (tempselx). Read data from APB passes straight back to AHB, and the response is always OKAY. It feeds the bridge FSM controller, which consumes valid, Haddr1/2, Hwdata1/2, Hwritereg and tempselx.

Parameters:
- none. Address map and widths are fixed: 32-bit address and data, 3 peripheral slots.

Ports:
- Hclk  in  1  system clock; all state updates on its rising edge
- Hresetn  in  1  reset; synchronous, active-high (asserted = 1), sampled on rising Hclk
- Hwrite  in  1  AHB transfer direction (1 = write)
- Hreadyin  in  1  AHB ready from bus; qualifies transfer
- Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- Haddr  in  32  AHB address
- Hwdata  in  32  AHB write data
- Prdata  in  32  APB read data returned by the selected peripheral
- valid  out  1  current address phase is a qualified, in-range transfer
- Haddr1  out  32  Haddr delayed 1 cycle
- Haddr2  out  32  Haddr delayed 2 cycles
- Hwdata1  out  32  Hwdata delayed 1 cycle
- Hwdata2  out  32  Hwdata delayed 2 cycles
- Hrdata  out  32  AHB read data
- Hwritereg  out  1  Hwrite delayed 1 cycle
- tempselx  out  3  one-hot peripheral select decoded from current Haddr
- Hresp  out  2  AHB response

Behaviour:
- Reset: on a rising edge with Hresetn=1, Haddr1, Haddr2, Hwdata1, Hwdata2 <= 0 and Hwritereg <= 0. Reset overrides all loads, including mid-burst. Combinational outputs are unaffected by reset.
- Pipeline (Hresetn=0): every rising edge, unconditionally (independent of Hreadyin/Htrans):
  - Haddr1 <= Haddr; Haddr2 <= Haddr1
  - Hwdata1 <= Hwdata; Hwdata2 <= Hwdata1
  - Hwritereg <= Hwrite
- Latency: 1 cycle to the *1 regs and Hwritereg; 2 cycles to the *2 regs. The first post-reset edge loads Haddr1 while Haddr2 still shows 0.
- valid (combinational) = Hreadyin AND Htrans[1] (NONSEQ or SEQ) AND 0x8000_0000 <= Haddr < 0x8C00_0000.
  - IDLE/BUSY, Hreadyin=0 or out-of-range address -> 0.
  - Boundaries: 0x8000_0000 gives 1; 0x8BFF_FFFF gives 1; 0x8C00_0000 and 0x7FFF_FFFF give 0.
- tempselx (combinational, from current Haddr, not qualified by Htrans/Hreadyin):
  - 0x8000_0000..0x83FF_FFFF -> 3'b001
  - 0x8400_0000..0x87FF_FFFF -> 3'b010
  - 0x8800_0000..0x8BFF_FFFF -> 3'b100
  - else -> 3'b000
  - Never more than one bit set.
- Hrdata = Prdata, combinational, zero latency, regardless of Hwrite.
- Hresp = 2'b00 (OKAY) constantly; no ERROR/RETRY/SPLIT generation.
- No internal state machine. The bridge FSM lives in the downstream controller.
- Combinational paths: Haddr/Htrans/Hreadyin -> valid/tempselx, and Prdata -> Hrdata. No registered output depends on valid.

Test Plan:
- Reset: drive Hresetn=1 for 1 edge with nonzero Haddr/Hwdata/Hwrite -> Haddr1=Haddr2=Hwdata1=Hwdata2=0, Hwritereg=0. Release; next edge -> Haddr1 loads, Haddr2 still 0.
- Write pipeline: NONSEQ write, Haddr=0x8000_0010, Hwdata=0x1234_5678, Hreadyin=1 -> valid=1 and tempselx=001 same cycle. After 1 edge Haddr1=0x8000_0010, Hwdata1=0x1234_5678, Hwritereg=1. After 2 edges Haddr2/Hwdata2 hold the same values.
- Read passthrough: Hwrite=0, Prdata=0xABCD_EF01 -> Hrdata=0xABCD_EF01 immediately, Hresp=00. Next edge Hwritereg=0.
- Decode: SEQ, Haddr=0x8400_0020 -> tempselx=010, valid=1. Haddr=0x8800_0000 -> 100. Haddr=0x8BFF_FFFF -> 100, valid=1.
- Invalid: Haddr=0x9000_0000 NONSEQ, Hreadyin=1 -> valid=0, tempselx=000. Haddr=0x8000_0000 with Htrans=00 or Hreadyin=0 -> valid=0, tempselx=001.
- Burst: consecutive Haddr 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C, 0x8000_0000 (wrap) on successive edges -> Haddr1 and Haddr2 track each at 1 and 2 cycle delay; valid=1 throughout.
